fibonacci_sequencer: RTL and testbench
======================================

FIBONACCI_SEQUENCER -- requirements
Module: fibonacci_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: width of the Fibonacci datapath and result.
REQ-002 Parameter IDXW, default 6: width of the requested index n.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 req_valid  input  1: request carries a valid index.
REQ-006 req_n  input  IDXW: requested index n; F(0)=0, F(1)=1.
REQ-007 req_ready  output  1: block can accept a request.
REQ-008 abort  input  1: cancels the computation in progress.
REQ-009 res_valid  output  1: result is available.
REQ-010 res_data  output  WIDTH: F(n), modulo 2^WIDTH.
REQ-011 res_ovf  output  1: F(n) is not representable in WIDTH bits.
REQ-012 res_ready  input  1: consumer accepts the result.
REQ-013 seq_valid  output  1: one intermediate series term per RUN cycle.
REQ-014 seq_data  output  WIDTH: current term a.
REQ-015 busy  output  1: state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE, with IDLE encoded as the reset state.
REQ-017 req_ready SHALL be 1 in IDLE and 0 in RUN, in DONE, and while rst_n is low.
REQ-018 On req_valid & req_ready at a clock edge, the block SHALL load a=0, b=1, cnt=req_n and ovf=0, and enter RUN.
REQ-019 A RUN cycle with cnt!=0 SHALL update a<=b, b<=(a+b) mod 2^WIDTH, cnt<=cnt-1.
REQ-020 A RUN cycle with cnt==0 SHALL latch res_data<=a and res_ovf<=ovf, and enter DONE.
REQ-021 Latency: res_valid SHALL rise exactly n+1 clock edges after the accepting edge.
REQ-022 In RUN, when cnt>=2 and a+b produces a carry out of bit WIDTH-1, ovf SHALL be set; ovf is sticky until the next load.
REQ-023 A carry produced while cnt==1 SHALL NOT set ovf, because that b value is never returned.
REQ-024 seq_valid SHALL be 1 in every RUN cycle with seq_data=a, and seq_valid SHALL be 0 in all other states.
REQ-025 In DONE, res_valid SHALL be 1 and res_data/res_ovf SHALL be held stable until res_valid & res_ready.
REQ-026 res_valid & res_ready SHALL return the FSM to IDLE, with res_valid=0 on the following cycle.
REQ-027 A new request SHALL NOT be accepted in the same cycle as the result handshake; the earliest acceptance is the first IDLE cycle.
REQ-028 abort in RUN SHALL return the FSM to IDLE at the next edge, with no result produced and res_valid remaining 0.
REQ-029 abort asserted in the cnt==0 RUN cycle SHALL take priority over completion.
REQ-030 abort SHALL be ignored in IDLE and DONE.
REQ-031 req_valid while req_ready=0 SHALL be ignored; requests are not queued.
REQ-032 res_data and res_ovf SHALL retain the last result in IDLE until overwritten by the next completion.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE and a=0, b=0, cnt=0, ovf=0, res_data=0, res_ovf=0.
REQ-034 During reset, res_valid, seq_valid, busy and req_ready SHALL all be 0.
REQ-035 Deassertion of rst_n SHALL take effect at the next rising clk edge, with req_ready=1 from that cycle.
REQ-036 rst_n asserted mid-RUN or in DONE SHALL discard the operation without producing any result.

Verification
REQ-037 Request n=10 with res_ready=1 -> seq_data steps 0,1,1,2,3,5,8,13,21,34,55; res_valid rises 11 edges after acceptance; res_data=55, res_ovf=0.
REQ-038 Request n=0, then separately n=1 -> res_data=0 and res_data=1 respectively, each with res_valid 1 and 2 edges after acceptance.
REQ-039 Request n=47, then n=48 -> n=47 gives res_data=2971215073, res_ovf=0; n=48 gives res_ovf=1 and res_data=512559680.
REQ-040 Request n=20, hold res_ready=0 for 5 cycles in DONE -> res_data=6765 stable and req_ready=0 throughout; release res_ready -> IDLE next cycle.
REQ-041 Request n=30 and pulse abort on the 5th RUN cycle -> IDLE next edge, res_valid never 1; then request n=5 -> res_data=5.
REQ-042 Request n=15 and drive rst_n low mid-RUN -> outputs zero asynchronously; after release, request n=7 -> res_data=13.

Source files
------------

// File: rtl/fibonacci_sequencer.sv
// Iterative Fibonacci engine: accepts an index n, walks the series one term per
// cycle while streaming each term, then holds F(n) mod 2^WIDTH plus an overflow flag.
module fibonacci_sequencer #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [IDXW-1:0]  req_n,
    output logic             req_ready,
    input  logic             abort,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    input  logic             res_ready,
    output logic             seq_valid,
    output logic [WIDTH-1:0] seq_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDXW-1:0]    cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_ovf_q, res_ovf_d;
    logic               out_of_reset_q;
    logic [WIDTH:0]     sum;

    // Keeps req_ready low until the first edge after rst_n releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_of_reset_q <= 1'b0;
        end else begin
            out_of_reset_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        sum        = {1'b0, a_q} + {1'b0, b_q};

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    a_d     = '0;
                    b_d     = {{(WIDTH-1){1'b0}}, 1'b1};
                    cnt_d   = req_n;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    res_data_d = a_q;
                    res_ovf_d  = ovf_q;
                    state_d    = S_DONE;
                end else begin
                    a_d   = b_q;
                    b_d   = sum[WIDTH-1:0];
                    cnt_d = cnt_q - IDXW'(1);
                    // The b formed at cnt==1 is never returned, so its carry is harmless.
                    if (sum[WIDTH] && (cnt_q > IDXW'(1))) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE) && out_of_reset_q;
    assign busy      = (state_q != S_IDLE);
    assign seq_valid = (state_q == S_RUN);
    assign seq_data  = a_q;
    assign res_valid = (state_q == S_DONE);
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Directed bench for fibonacci_sequencer: a vector table of n -> F(n)/overflow
// plus hand-written sequences for hold, abort and mid-run reset.
module tb_fibonacci_sequencer;

    localparam int WIDTH = 32;
    localparam int IDXW  = 6;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic [IDXW-1:0]  req_n;
    logic             req_ready;
    logic             abort;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;
    logic             res_ready;
    logic             seq_valid;
    logic [WIDTH-1:0] seq_data;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int               n;
        logic [WIDTH-1:0] exp_data;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[9];
    int   seq_q[$];

    fibonacci_sequencer #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_n     (req_n),
        .req_ready (req_ready),
        .abort     (abort),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .seq_valid (seq_valid),
        .seq_data  (seq_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Called just after a rising edge. Issues n, waits (bounded) for res_valid,
    // collecting streamed terms. Returns with the DUT in DONE.
    task automatic do_req(input int n, output logic [WIDTH-1:0] d, output logic o,
                          output int lat);
        chk("req_ready_before_request", {63'd0, req_ready}, 64'd1);
        seq_q.delete();
        req_valid = 1'b1;
        req_n     = IDXW'(n);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 200) begin
            if (seq_valid) seq_q.push_back(int'(seq_data));
            @(posedge clk);
            #1;
            lat++;
        end
        if (!res_valid) begin
            failures++;
            $display("FAIL timeout_waiting_res_valid n=%0d actual=0 required=1", n);
        end
        d = res_data;
        o = res_ovf;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout actual=expired required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [WIDTH-1:0] d;
        logic             o;
        int               lat;
        int               seen;
        int               exp_seq[11];

        vecs[0] = '{0,  32'd0,          1'b0};
        vecs[1] = '{1,  32'd1,          1'b0};
        vecs[2] = '{2,  32'd1,          1'b0};
        vecs[3] = '{3,  32'd2,          1'b0};
        vecs[4] = '{10, 32'd55,         1'b0};
        vecs[5] = '{20, 32'd6765,       1'b0};
        vecs[6] = '{47, 32'd2971215073, 1'b0};
        vecs[7] = '{48, 32'd512559680,  1'b1};
        vecs[8] = '{49, 32'd3483774753, 1'b1};
        exp_seq = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_n     = '0;
        abort     = 1'b0;
        res_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_seq_valid", {63'd0, seq_valid}, 64'd0);
        chk("rst_res_data",  64'(res_data),      64'd0);
        rst_n = 1'b1;
        #2;
        chk("req_ready_before_first_edge", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("req_ready_after_first_edge", {63'd0, req_ready}, 64'd1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].n, d, o, lat);
            $display("vec n=%0d data=%0d ovf=%0d latency=%0d", vecs[i].n, d, o, lat);
            chk($sformatf("data_n%0d", vecs[i].n), 64'(d), 64'(vecs[i].exp_data));
            chk($sformatf("ovf_n%0d", vecs[i].n), {63'd0, o}, {63'd0, vecs[i].exp_ovf});
            chk($sformatf("latency_n%0d", vecs[i].n), 64'(lat), 64'(vecs[i].n + 1));
            if (vecs[i].n == 10) begin
                chk("seq_len_n10", 64'(seq_q.size()), 64'd11);
                for (int k = 0; k < 11 && k < seq_q.size(); k++)
                    chk($sformatf("seq_n10_%0d", k), 64'(seq_q[k]), 64'(exp_seq[k]));
            end
            @(posedge clk);
            #1;
            chk("handshake_res_valid_low", {63'd0, res_valid}, 64'd0);
            chk("handshake_req_ready",     {63'd0, req_ready}, 64'd1);
            chk("res_data_retained_idle",  64'(res_data), 64'(vecs[i].exp_data));
        end

        // Hold in DONE with res_ready low; stray req/abort must be ignored
        res_ready = 1'b0;
        do_req(20, d, o, lat);
        $display("hold n=20 data=%0d latency=%0d", d, lat);
        chk("hold_data_initial", 64'(d), 64'd6765);
        req_valid = 1'b1;
        req_n     = IDXW'(3);
        abort     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_res_valid_%0d", k), {63'd0, res_valid}, 64'd1);
            chk($sformatf("hold_res_data_%0d", k),  64'(res_data),      64'd6765);
            chk($sformatf("hold_req_ready_%0d", k), {63'd0, req_ready}, 64'd0);
        end
        abort     = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("hold release res_valid=%0d busy=%0d", res_valid, busy);
        chk("hold_release_res_valid", {63'd0, res_valid}, 64'd0);
        chk("no_accept_on_handshake", {63'd0, busy},      64'd0);

        // Abort on 5th RUN cycle of n=30
        req_valid = 1'b1;
        req_n     = IDXW'(30);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_seq_data_cycle5", 64'(seq_data), 64'd3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        $display("abort n=30 busy=%0d res_valid=%0d", busy, res_valid);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (res_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        do_req(5, d, o, lat);
        $display("after abort n=5 data=%0d latency=%0d", d, lat);
        chk("after_abort_data", 64'(d), 64'd5);
        @(posedge clk);
        #1;

        // Abort in the cnt==0 cycle beats completion
        req_valid = 1'b1;
        req_n     = IDXW'(2);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_last_seq_data", 64'(seq_data), 64'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        $display("abort at cnt0 busy=%0d res_valid=%0d res_data=%0d", busy, res_valid, res_data);
        chk("abort_cnt0_busy",      {63'd0, busy},      64'd0);
        chk("abort_cnt0_res_valid", {63'd0, res_valid}, 64'd0);
        chk("abort_cnt0_res_data",  64'(res_data),      64'd5);

        // Reset mid-RUN
        req_valid = 1'b1;
        req_n     = IDXW'(15);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        $display("mid-run reset res_data=%0d seq_data=%0d busy=%0d", res_data, seq_data, busy);
        chk("mrst_res_data",  64'(res_data),      64'd0);
        chk("mrst_seq_data",  64'(seq_data),      64'd0);
        chk("mrst_seq_valid", {63'd0, seq_valid}, 64'd0);
        chk("mrst_busy",      {63'd0, busy},      64'd0);
        chk("mrst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("mrst_res_valid", {63'd0, res_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(7, d, o, lat);
        $display("after reset n=7 data=%0d latency=%0d", d, lat);
        chk("after_reset_data",    64'(d),   64'd13);
        chk("after_reset_latency", 64'(lat), 64'd8);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
